// File: rtl/rle_stream_encoder.sv
// rle_stream_encoder
// Run-length encoder for a valid/ready symbol stream.
//
// Runs of identical symbols are emitted either as an escaped triple
// (ESC_SYM, run length, symbol) or as plain literal repeats of the symbol.
// The escaped form is used when the run is at least MIN_RUN long, or when
// the symbol is ESC_SYM itself, so a literal escape byte never reaches the
// output.
//
// A symbol that breaks a run is held in a one-entry pending register while
// the closed run drains. It then seeds the next run.
//
// Optional feature: define RLE_STATS_EN to add the stat_in_words and
// stat_out_words handshake counters.
module rle_stream_encoder #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] ESC_SYM = DATA_W'(8'h1B),
  parameter int                MIN_RUN = 3
) (
  input  logic              data_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
`ifdef RLE_STATS_EN
  output logic [31:0]       stat_in_words,
  output logic [31:0]       stat_out_words,
`endif
  output logic              busy
);

  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
  localparam logic [DATA_W-1:0] TWO       = DATA_W'(2);
  localparam logic [DATA_W-1:0] ZERO      = DATA_W'(0);
  localparam logic [DATA_W-1:0] MAX_LEN   = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MIN_RUN_W = DATA_W'(MIN_RUN);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    EMIT_ESC = 3'd2,
    EMIT_CNT = 3'd3,
    EMIT_SYM = 3'd4,
    EMIT_LIT = 3'd5
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] cur_sym_r;
  logic [DATA_W-1:0] run_len_r;
  logic              run_last_r;
  logic              pend_valid_r;
  logic [DATA_W-1:0] pend_data_r;
  logic              pend_last_r;

  logic              in_fire_s;
  logic              out_fire_s;
  logic              final_s;
  logic [DATA_W-1:0] inc_len_s;
  logic              close_s;
  logic [DATA_W-1:0] close_sym_s;
  logic [DATA_W-1:0] close_len_s;
  logic              close_last_s;
  logic              close_esc_s;

  // A run goes out escaped when it is long enough, or when a literal would
  // be mistaken for an escape marker.
  function automatic logic use_escape(input logic [DATA_W-1:0] sym,
                                      input logic [DATA_W-1:0] len);
    return (len >= MIN_RUN_W) || (sym == ESC_SYM);
  endfunction

  assign in_ready   = (state_r == IDLE) || (state_r == ACCUM);
  assign busy       = (state_r != IDLE) || out_valid;
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;
  assign inc_len_s  = run_len_r + ONE;
  // The last word of a run is the symbol word (escaped) or the final repeat.
  assign final_s    = out_fire_s &&
                      ((state_r == EMIT_SYM) ||
                       ((state_r == EMIT_LIT) && (run_len_r == ONE)));
  assign close_esc_s = use_escape(close_sym_s, close_len_s);

  // Decide whether a run closes on this edge, and with which symbol, length and last flag.
  always_comb begin
    close_s      = 1'b0;
    close_sym_s  = cur_sym_r;
    close_len_s  = run_len_r;
    close_last_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_fire_s && in_last) begin
          close_s      = 1'b1;
          close_sym_s  = in_data;
          close_len_s  = ONE;
          close_last_s = 1'b1;
        end else begin
          close_s = 1'b0;
        end
      end
      ACCUM: begin
        if (in_fire_s) begin
          if (in_data == cur_sym_r) begin
            close_len_s  = inc_len_s;
            close_last_s = in_last;
            close_s      = in_last || (inc_len_s == MAX_LEN);
          end else begin
            // Mismatching symbol: it is parked as pending, and the current run closes.
            close_s      = 1'b1;
            close_last_s = 1'b0;
          end
        end else begin
          close_s = 1'b0;
        end
      end
      EMIT_SYM, EMIT_LIT: begin
        if (final_s && pend_valid_r && pend_last_r) begin
          // A pending word that ended the packet is a complete one-symbol run.
          close_s      = 1'b1;
          close_sym_s  = pend_data_r;
          close_len_s  = ONE;
          close_last_s = 1'b1;
        end else begin
          close_s = 1'b0;
        end
      end
      default: begin
        close_s = 1'b0;
      end
    endcase
  end

  // Main FSM: accumulate runs, drain encoded words, and reload from the pending register.
  always_ff @(posedge data_clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cur_sym_r    <= ZERO;
      run_len_r    <= ZERO;
      run_last_r   <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_data_r  <= ZERO;
      pend_last_r  <= 1'b0;
      out_data     <= ZERO;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_fire_s) begin
            cur_sym_r <= in_data;
            run_len_r <= ONE;
            state_r   <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire_s) begin
            if (in_data == cur_sym_r) begin
              run_len_r <= inc_len_s;
            end else begin
              pend_valid_r <= 1'b1;
              pend_data_r  <= in_data;
              pend_last_r  <= in_last;
            end
          end
        end
        EMIT_ESC: begin
          if (out_fire_s) begin
            out_data <= run_len_r;
            state_r  <= EMIT_CNT;
          end
        end
        EMIT_CNT: begin
          if (out_fire_s) begin
            out_data <= cur_sym_r;
            out_last <= run_last_r;
            state_r  <= EMIT_SYM;
          end
        end
        EMIT_SYM, EMIT_LIT: begin
          if (final_s) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (pend_valid_r) begin
              cur_sym_r    <= pend_data_r;
              run_len_r    <= ONE;
              run_last_r   <= 1'b0;
              pend_valid_r <= 1'b0;
              pend_last_r  <= 1'b0;
              state_r      <= ACCUM;
            end else begin
              run_len_r <= ZERO;
              state_r   <= IDLE;
            end
          end else if (out_fire_s) begin
            // Literal repeat handed over; the remaining-count lives in run_len_r.
            run_len_r <= run_len_r - ONE;
            out_last  <= run_last_r && (run_len_r == TWO);
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
      // A closing run overrides the per-state updates and loads its first word.
      if (close_s) begin
        cur_sym_r  <= close_sym_s;
        run_len_r  <= close_len_s;
        run_last_r <= close_last_s;
        out_valid  <= 1'b1;
        if (close_esc_s) begin
          state_r  <= EMIT_ESC;
          out_data <= ESC_SYM;
          out_last <= 1'b0;
        end else begin
          state_r  <= EMIT_LIT;
          out_data <= close_sym_s;
          out_last <= close_last_s && (close_len_s == ONE);
        end
      end
    end
  end

`ifdef RLE_STATS_EN
  // Wrapping counters of accepted input and output handshakes.
  always_ff @(posedge data_clk) begin
    if (reset) begin
      stat_in_words  <= 32'd0;
      stat_out_words <= 32'd0;
    end else begin
      if (in_fire_s) begin
        stat_in_words <= stat_in_words + 32'd1;
      end
      if (out_fire_s) begin
        stat_out_words <= stat_out_words + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rle_stream_encoder.md
RLE_STREAM_ENCODER -- requirements
Module: rle_stream_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning symbol and count width in bits.
REQ-002 SHALL have parameter ESC_SYM, default 8'h1B (DATA_W bits), meaning the escape symbol.
REQ-003 SHALL have parameter MIN_RUN, default 3, meaning the shortest run emitted in escaped form.
REQ-004 SHALL have port data_clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  DATA_W  input symbol.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_last  input  1  last symbol of the packet.
REQ-009 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-010 SHALL have ports out_data  output  DATA_W, out_valid  output  1 and out_last  output  1, meaning the encoded word, its valid flag, and the final word of the packet.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE or out_valid=1.

Function
REQ-013 SHALL transfer input only when in_valid=1 and in_ready=1, and output only when out_valid=1 and out_ready=1.
REQ-014 SHALL use states IDLE, ACCUM, EMIT_ESC, EMIT_CNT, EMIT_SYM and EMIT_LIT, and SHALL drive in_ready=1 only in IDLE and ACCUM.
REQ-015 SHALL, in IDLE on accept: set cur_sym=in_data and run_len=1; go to ACCUM, or close the run if in_last=1.
REQ-016 SHALL, in ACCUM, when in_data==cur_sym: increment run_len; close the run if in_last=1 or run_len reaches 2^DATA_W-1.
REQ-017 SHALL, in ACCUM, when in_data!=cur_sym: store the word and its in_last in a one-entry pending register, then close the current run.
REQ-018 SHALL close a run in escaped form (ESC_SYM, run_len, cur_sym via EMIT_ESC/EMIT_CNT/EMIT_SYM) when run_len>=MIN_RUN or cur_sym==ESC_SYM.
REQ-019 SHALL otherwise close a run in literal form: cur_sym emitted run_len times via EMIT_LIT.
REQ-020 SHALL present the first encoded word with out_valid=1 on the cycle after the closing edge.
REQ-021 SHALL emit at most one word per cycle.
REQ-022 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL assert out_last only on the final word of a run closed by in_last.
REQ-024 SHALL, after the final word handshakes: load any pending word as a new run (run_len=1) and enter ACCUM, or close it immediately if its last=1; with no pending word, SHALL return to IDLE.
REQ-025 SHALL treat a run that saturates at 2^DATA_W-1 as closed; the next matching symbol starts a new run.
REQ-026 SHALL never drop or duplicate input symbols under any out_ready pattern.

Reset
REQ-027 SHALL, on reset=1 at a clock edge: state=IDLE, run_len=0, pending register cleared, out_valid=0, out_last=0, out_data=0, in_ready=1, busy=0.
REQ-028 SHALL discard any partial run and pending word when reset is asserted mid-packet; reset has priority over all handshakes in that cycle.

Configuration
REQ-029 SHALL, when macro RLE_STATS_EN is defined, add outputs stat_in_words (32 bits) and stat_out_words (32 bits): wrapping counts of accepted input and output handshakes, cleared by reset.
REQ-030 SHALL, without RLE_STATS_EN, omit these ports and counters with no other behavioural change.

Verification
REQ-031 SHALL cover: 5x 0x41, in_last on the 5th -> out 0x1B, 0x05, 0x41; out_last on 0x41.
REQ-032 SHALL cover: 0x41, 0x41, 0x42 (last) -> out 0x41, 0x41, 0x42; out_last on 0x42.
REQ-033 SHALL cover: single 0x1B with last -> out 0x1B, 0x01, 0x1B; out_last on the third word.
REQ-034 SHALL cover: 300x 0x00, last on the 300th -> out 0x1B, 0xFF, 0x00, 0x1B, 0x2D, 0x00; out_last on the final 0x00.
REQ-035 SHALL cover: REQ-031 stimulus with out_ready=0 for 4 cycles while 0x05 is presented -> 0x05 held stable; same 3-word output; no loss.
REQ-036 SHALL cover: reset after 3 words of a 0x55 run, then 0x07 with last -> nothing emitted for the 0x55 run; out 0x07 with out_last.
